// File: rtl/mips_cpu_lsu_pkg.sv
// Shared definitions for the MIPS CPU load/store path: FSM states, the
// opcode[28:26] load/store encodings, and the bus/register byte-order swap.
`timescale 1ns/1ps
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP,
        S_FAULT
    } lsu_state_t;

    localparam logic [2:0] OP_B      = 3'b000;
    localparam logic [2:0] OP_H      = 3'b001;
    localparam logic [2:0] OP_WL     = 3'b010;
    localparam logic [2:0] OP_W      = 3'b011;
    localparam logic [2:0] OP_BU     = 3'b100;
    localparam logic [2:0] OP_HU     = 3'b101;
    localparam logic [2:0] OP_WR     = 3'b110;
    localparam logic [2:0] OP_UNUSED = 3'b111;

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_if.sv
// Avalon-MM data-bus bundle between the load/store unit and memory.
`timescale 1ns/1ps
interface mips_cpu_lsu_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/mips_cpu_lsu_align.sv
// Combinational load extractor: selects, extends or merges a register-order
// word W (byte 0 = most significant) according to the load op and ea[1:0].
`timescale 1ns/1ps
module mips_cpu_lsu_align
    import mips_cpu_pkg::*;
(
    input  logic [31:0] w,
    input  logic [1:0]  k,
    input  logic [2:0]  op,
    input  logic [31:0] rt_data,
    output logic [31:0] result
);

    logic [4:0]  sh_hi;
    logic [4:0]  sh_lo;
    logic [31:0] byte_word;
    logic [7:0]  b;
    logic [15:0] half;

    always_comb begin
        // sh_hi = 8*k, sh_lo = 8*(3-k)
        sh_hi     = {k, 3'b000};
        sh_lo     = {~k, 3'b000};
        byte_word = w >> sh_lo;
        b         = byte_word[7:0];
        half      = k[1] ? w[15:0] : w[31:16];
        result    = '0;
        case (op)
            OP_B:    result = b[7] ? {24'hFF_FFFF, b} : {24'h00_0000, b};
            OP_BU:   result = {24'h00_0000, b};
            OP_H:    result = half[15] ? {16'hFFFF, half} : {16'h0000, half};
            OP_HU:   result = {16'h0000, half};
            OP_W:    result = w;
            OP_WL:   result = (w << sh_hi) | (rt_data & ~(32'hFFFF_FFFF << sh_hi));
            OP_WR:   result = (w >> sh_lo) | (rt_data & ~(32'hFFFF_FFFF >> sh_lo));
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Multi-cycle load/store unit: effective-address generation, Avalon-MM access
// with waitrequest handshake, load alignment and store lane placement.
`timescale 1ns/1ps
module mips_cpu_lsu
    import mips_cpu_pkg::*;
#(
    parameter bit BYTE_SWAP         = 1'b1,
    parameter bit FAULT_ON_MISALIGN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          is_store,
    input  logic [2:0]    op,
    input  logic [31:0]   base,
    input  logic [15:0]   offset,
    input  logic [31:0]   rt_data,
    input  logic [4:0]    rt_index,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic          reg_write_en,
    output logic [4:0]    reg_write_index,
    output logic [31:0]   reg_write_data,
    mips_cpu_lsu_if.master bus
);

    lsu_state_t  state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] rt_data_q, rt_data_d;
    logic [4:0]  rt_index_q, rt_index_d;
    logic [31:0] ea_q, ea_d;
    logic [31:0] result_q, result_d;

    logic [31:0] ea_calc, ea_fixed, bus_word, align_result, wd_raw;
    logic        is_half, is_word, unsupported, misaligned;

    always_comb begin
        ea_calc     = base + {{16{offset[15]}}, offset};
        is_half     = (op == OP_H) || (!is_store && op == OP_HU);
        is_word     = (op == OP_W);
        unsupported = is_store ? !(op == OP_B || op == OP_H || op == OP_W)
                               : (op == OP_UNUSED);
        misaligned  = (is_half && ea_calc[0]) || (is_word && ea_calc[1:0] != 2'b00);
        // Without faulting, the offending low bits are cleared so the access proceeds aligned
        ea_fixed    = ea_calc;
        if (!FAULT_ON_MISALIGN) begin
            if (is_half) ea_fixed[0]   = 1'b0;
            if (is_word) ea_fixed[1:0] = 2'b00;
        end
        bus_word = BYTE_SWAP ? byte_swap(bus.readdata) : bus.readdata;
    end

    mips_cpu_lsu_align u_align (
        .w       (bus_word),
        .k       (ea_q[1:0]),
        .op      (op_q),
        .rt_data (rt_data_q),
        .result  (align_result)
    );

    always_comb begin
        state_d        = state_q;
        is_store_d     = is_store_q;
        op_d           = op_q;
        rt_data_d      = rt_data_q;
        rt_index_d     = rt_index_q;
        ea_d           = ea_q;
        result_d       = result_q;
        done           = 1'b0;
        fault          = 1'b0;
        reg_write_en   = 1'b0;
        reg_write_data = '0;
        bus.address    = '0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.byteenable = '0;
        bus.writedata  = '0;
        wd_raw         = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    op_d       = op;
                    rt_data_d  = rt_data;
                    rt_index_d = rt_index;
                    ea_d       = ea_fixed;
                    state_d    = (unsupported || (FAULT_ON_MISALIGN && misaligned))
                                 ? S_FAULT : S_ACCESS;
                end
            end
            S_ACCESS: begin
                bus.address = {ea_q[31:2], 2'b00};
                bus.read    = !is_store_q;
                bus.write   = is_store_q;
                if (is_store_q) begin
                    case (op_q)
                        OP_B: begin
                            bus.byteenable = 4'b0001 << ea_q[1:0];
                            wd_raw         = {4{rt_data_q[7:0]}};
                        end
                        OP_H: begin
                            bus.byteenable = ea_q[1] ? 4'b1100 : 4'b0011;
                            wd_raw         = {2{rt_data_q[15:0]}};
                        end
                        default: begin
                            bus.byteenable = 4'b1111;
                            wd_raw         = rt_data_q;
                        end
                    endcase
                    bus.writedata = BYTE_SWAP ? byte_swap(wd_raw) : wd_raw;
                end else begin
                    bus.byteenable = 4'b1111;
                end
                if (!bus.waitrequest) begin
                    if (!is_store_q) result_d = align_result;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                done           = 1'b1;
                reg_write_en   = !is_store_q;
                reg_write_data = is_store_q ? '0 : result_q;
                state_d        = S_IDLE;
            end
            S_FAULT: begin
                done    = 1'b1;
                fault   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy            = (state_q != S_IDLE);
    assign reg_write_index = rt_index_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            op_q       <= '0;
            rt_data_q  <= '0;
            rt_index_q <= '0;
            ea_q       <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            op_q       <= op_d;
            rt_data_q  <= rt_data_d;
            rt_index_q <= rt_index_d;
            ea_q       <= ea_d;
            result_q   <= result_d;
        end
    end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Scoreboard bench for mips_cpu_lsu: big-endian byte-memory reference model,
// stalling Avalon slave, directed cases plus randomized traffic.
`timescale 1ns/1ps
module tb_mips_cpu_lsu;
    import mips_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, is_store;
    logic [2:0]  op;
    logic [31:0] base, rt_data;
    logic [15:0] offset;
    logic [4:0]  rt_index;
    logic        busy, done, fault, reg_write_en;
    logic [4:0]  reg_write_index;
    logic [31:0] reg_write_data;

    mips_cpu_lsu_if bus ();

    mips_cpu_lsu #(.BYTE_SWAP(1'b1), .FAULT_ON_MISALIGN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store), .op(op),
        .base(base), .offset(offset), .rt_data(rt_data), .rt_index(rt_index),
        .busy(busy), .done(done), .fault(fault), .reg_write_en(reg_write_en),
        .reg_write_index(reg_write_index), .reg_write_data(reg_write_data),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flt;
        logic        wen;
        logic [31:0] data;
        logic [4:0]  idx;
        int unsigned lat;
        int unsigned t0;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
    } xfer_t;

    resp_t       sb_q[$];
    xfer_t       bus_q[$];
    logic [7:0]  ref_mem [256];   // reference: big-endian byte memory
    logic [31:0] bus_mem [64];    // slave: bus words, lane j = byte address 4A+j
    int unsigned checks = 0, errors = 0, cyc = 0, done_cnt = 0, stall_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [69:0] snap = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Avalon slave + bus monitor + response monitor
    always @(negedge clk) begin
        logic        req;
        logic [69:0] now;
        xfer_t       x;
        resp_t       r;
        req = bus.read | bus.write;
        now = {bus.address, bus.read, bus.write, bus.byteenable, bus.writedata};
        if (prev_stall && !reset)
            chk("bus_stable", 32'(now === snap), 32'd1);
        if (req && stall_cnt > 0) begin
            bus.waitrequest = 1'b1;
            stall_cnt--;
        end else begin
            bus.waitrequest = 1'b0;
        end
        bus.readdata = bus_mem[bus.address[7:2]];
        if (req && !bus.waitrequest) begin
            if (bus_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_xfer: actual addr=%h required none", bus.address);
            end else begin
                x = bus_q.pop_front();
                chk("xfer_addr", bus.address, x.addr);
                chk("xfer_dir", 32'(bus.write), 32'(x.we));
                chk("xfer_be", 32'(bus.byteenable), 32'(x.be));
                if (x.we) chk("xfer_wdata", bus.writedata, x.wd);
            end
            if (bus.write)
                for (int j = 0; j < 4; j++)
                    if (bus.byteenable[j]) bus_mem[bus.address[7:2]][8*j +: 8] = bus.writedata[8*j +: 8];
        end
        prev_stall = req && bus.waitrequest;
        snap       = now;
        if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: actual done=1 required 0 (t=%0t)", $time);
            end else begin
                r = sb_q.pop_front();
                chk("fault", 32'(fault), 32'(r.flt));
                chk("reg_write_en", 32'(reg_write_en), 32'(r.wen));
                if (r.wen) begin
                    chk("reg_write_data", reg_write_data, r.data);
                    chk("reg_write_index", 32'(reg_write_index), 32'(r.idx));
                end
                chk("latency", cyc - r.t0, r.lat);
            end
        end
        if (reg_write_en && !done) begin
            checks++; errors++;
            $display("FAIL stray_wen: actual reg_write_en=1 required 0");
        end
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        logic [7:0] bi;
        bus_mem[a[7:2]] = w;
        for (int j = 0; j < 4; j++) begin
            bi = {a[7:2], 2'(j)};
            ref_mem[bi] = w[8*j +: 8];
        end
    endtask

    function automatic bit model_fault(input bit st, input logic [2:0] o, input logic [31:0] ea);
        bit bad, half, word;
        bad  = st ? !(o == OP_B || o == OP_H || o == OP_W) : (o == 3'b111);
        half = (o == OP_H) || (!st && o == OP_HU);
        word = (o == OP_W);
        return bad || (half && ea[0]) || (word && ea[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] o, input logic [31:0] ea,
                                               input logic [31:0] rt);
        logic [7:0]  a, wb;
        int          k;
        logic [31:0] r;
        a  = ea[7:0];
        wb = {a[7:2], 2'b00};
        k  = int'(ea[1:0]);
        r  = '0;
        case (o)
            OP_B:  r = {{24{ref_mem[a][7]}}, ref_mem[a]};
            OP_BU: r = {24'h0, ref_mem[a]};
            OP_H:  r = {{16{ref_mem[a][7]}}, ref_mem[a], ref_mem[8'(a + 1)]};
            OP_HU: r = {16'h0, ref_mem[a], ref_mem[8'(a + 1)]};
            OP_W:  r = {ref_mem[wb], ref_mem[8'(wb + 1)], ref_mem[8'(wb + 2)], ref_mem[8'(wb + 3)]};
            OP_WL: begin
                r = rt;
                for (int i = 0; i <= 3 - k; i++) r[31 - 8*i -: 8] = ref_mem[8'(a + i)];
            end
            OP_WR: begin
                r = rt;
                for (int j = 0; j <= k; j++) r[31 - 8*(3 - k + j) -: 8] = ref_mem[8'(wb + j)];
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_store(input logic [2:0] o, input logic [31:0] ea, input logic [31:0] rt,
                               output xfer_t x);
        logic [7:0] a, wb;
        a      = ea[7:0];
        wb     = {a[7:2], 2'b00};
        x.addr = {ea[31:2], 2'b00};
        x.we   = 1'b1;
        x.be   = '0;
        x.wd   = '0;
        case (o)
            OP_B: begin
                ref_mem[a] = rt[7:0];
                x.be[a[1:0]] = 1'b1;
                for (int j = 0; j < 4; j++) x.wd[8*j +: 8] = rt[7:0];
            end
            OP_H: begin
                ref_mem[a] = rt[15:8];
                ref_mem[8'(a + 1)] = rt[7:0];
                x.be[a[1:0]] = 1'b1;
                x.be[2'(a[1:0] + 1)] = 1'b1;
                for (int j = 0; j < 4; j++) x.wd[8*j +: 8] = (j % 2 == 0) ? rt[15:8] : rt[7:0];
            end
            default: begin
                x.be = 4'hF;
                for (int j = 0; j < 4; j++) begin
                    ref_mem[8'(wb + j)] = rt[31 - 8*j -: 8];
                    x.wd[8*j +: 8] = rt[31 - 8*j -: 8];
                end
            end
        endcase
    endtask

    task automatic issue(input bit st, input logic [2:0] o, input logic [31:0] b,
                         input logic [15:0] off, input logic [31:0] rt, input logic [4:0] idx,
                         input int unsigned stalls, input bit use_lit, input logic [31:0] lit);
        logic [31:0] ea;
        resp_t       r;
        xfer_t       x;
        int unsigned d0;
        bit          got;
        ea     = b + {{16{off[15]}}, off};
        r.flt  = model_fault(st, o, ea);
        r.wen  = !r.flt && !st;
        r.idx  = idx;
        r.lat  = r.flt ? 1 : 2 + stalls;
        r.data = '0;
        if (!r.flt) begin
            if (st) begin
                model_store(o, ea, rt, x);
            end else begin
                r.data = use_lit ? lit : model_load(o, ea, rt);
                x.addr = {ea[31:2], 2'b00};
                x.we   = 1'b0;
                x.be   = 4'hF;
                x.wd   = '0;
            end
            bus_q.push_back(x);
        end
        r.t0 = cyc;
        sb_q.push_back(r);
        stall_cnt = r.flt ? 0 : stalls;
        is_store = st; op = o; base = b; offset = off; rt_data = rt; rt_index = idx;
        start = 1'b1;
        d0  = done_cnt;
        got = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done_cnt != d0) begin
                got = 1'b1;
                break;
            end
            // start while busy must be ignored
            if (busy && $urandom_range(0, 3) == 0) begin
                start = 1'b1; is_store = 1'($urandom); op = 3'($urandom);
                base = $urandom; offset = 16'($urandom); rt_data = $urandom;
                rt_index = 5'($urandom);
            end
        end
        start = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL done_timeout: actual no done in 64 cycles required done");
            sb_q.delete(); bus_q.delete(); stall_cnt = 0;
        end
    endtask

    initial begin
        bit          st;
        logic [2:0]  o;
        logic [31:0] b;
        logic [15:0] off;
        reset = 1'b1; start = 1'b0; is_store = 1'b0; op = '0; base = '0;
        offset = '0; rt_data = '0; rt_index = '0;
        for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_wen", 32'(reg_write_en), 32'd0);
        chk("rst_rw", 32'({bus.read, bus.write}), 32'd0);
        chk("rst_addr", bus.address, 32'd0);
        chk("rst_be", 32'(bus.byteenable), 32'd0);
        chk("rst_wdata", bus.writedata, 32'd0);
        chk("rst_rwdata", reg_write_data, 32'd0);
        chk("rst_rwidx", 32'(reg_write_index), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        preload(32'h1000, 32'h80FF7F01);
        issue(1'b0, OP_B,  32'h1000, 16'h0000, 32'h0, 5'd1, 0, 1'b1, 32'h0000_0001);
        issue(1'b0, OP_B,  32'h1000, 16'h0003, 32'h0, 5'd2, 0, 1'b1, 32'hFFFF_FF80);
        issue(1'b0, OP_BU, 32'h1000, 16'h0003, 32'h0, 5'd3, 1, 1'b1, 32'h0000_0080);
        preload(32'h2000, 32'h00000080);
        issue(1'b0, OP_H,  32'h2000, 16'h0002, 32'h0, 5'd4, 0, 1'b1, 32'h0000_0000);
        issue(1'b0, OP_H,  32'h2000, 16'h0000, 32'h0, 5'd5, 0, 1'b1, 32'hFFFF_8000);
        issue(1'b0, OP_HU, 32'h2000, 16'h0000, 32'h0, 5'd6, 2, 1'b1, 32'h0000_8000);
        issue(1'b0, OP_H,  32'h2001, 16'h0000, 32'h0, 5'd7, 0, 1'b0, 32'h0);
        issue(1'b1, OP_B,  32'h0010, 16'hFFF3, 32'h0000_00AB, 5'd0, 3, 1'b0, 32'h0);
        preload(32'h0100, 32'hDDCCBBAA);
        issue(1'b0, OP_WL, 32'h0100, 16'h0001, 32'h1122_3344, 5'd8, 0, 1'b1, 32'hBBCC_DD44);
        issue(1'b0, OP_WR, 32'h0100, 16'h0001, 32'h1122_3344, 5'd9, 0, 1'b1, 32'h1122_AABB);

        // reset while the read is stalled
        is_store = 1'b0; op = OP_W; base = 32'h40; offset = '0; rt_index = 5'd3;
        stall_cnt = 10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_read", 32'(bus.read), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_read", 32'(bus.read), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        stall_cnt = 0;
        bus_q.delete();
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        issue(1'b0, OP_B, 32'h1000, 16'h0001, 32'h0, 5'd10, 0, 1'b0, 32'h0);

        for (int n = 0; n < 300; n++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                if (st) begin
                    case ($urandom_range(0, 2))
                        0:       o = OP_B;
                        1:       o = OP_H;
                        default: o = OP_W;
                    endcase
                end else begin
                    o = 3'($urandom_range(0, 6));
                end
            end else begin
                o = 3'($urandom_range(0, 7));
            end
            b   = $urandom;
            off = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                b[1:0]   = 2'b00;
                off[1:0] = 2'b00;
            end
            issue(st, o, b, off, $urandom, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3), 1'b0, 32'h0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("bus_drained", 32'(bus_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
